// File: rtl/rv_alu2.sv
// rv_alu2 - execute stage: integer ALU, branch/jump resolution and a
// registered front-end redirect on misprediction.
//
// Shifts with a non-zero amount can run on an iterative 1-bit/cycle shifter
// (SERIAL_SHIFT=1), which holds o_stall high while it runs; otherwise every
// operation completes in a single cycle.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_flush                kill the in-flight and the incoming instruction
//   i_valid                instruction present at the stage input
//   i_op1, i_op2           selected ALU operands
//   i_reg_data1/2          raw rs1/rs2 data (branch compare, store data)
//   i_alu_op               ALU operation (10-15 behave as ADD)
//   i_funct3               branch condition / memory size (passed through)
//   i_inst_branch, i_inst_jal_jalr, i_branch_pred
//                          instruction class and front-end taken prediction
//   i_pc_next, i_pc_target fall-through address and computed target
//   i_rd, i_reg_write, i_store, i_res_src   passed through
//   o_stall                upstream must hold its registers
//   o_valid                registered result valid
//   o_result, o_store_data, o_rd, o_reg_write, o_store, o_res_src, o_funct3
//   o_redirect, o_redirect_pc   one-cycle front-end redirect and its address
//
// State table:
//   IDLE  | ready to accept; single-cycle results are registered from here
//   SHIFT | iterative shift in progress, o_stall high, inputs ignored
module rv_alu2 #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int SERIAL_SHIFT     = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic                        i_valid,
    input  logic [31:0]                 i_op1,
    input  logic [31:0]                 i_op2,
    input  logic [31:0]                 i_reg_data1,
    input  logic [31:0]                 i_reg_data2,
    input  logic [3:0]                  i_alu_op,
    input  logic [2:0]                  i_funct3,
    input  logic                        i_inst_branch,
    input  logic                        i_inst_jal_jalr,
    input  logic                        i_branch_pred,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
    input  logic [4:0]                  i_rd,
    input  logic                        i_reg_write,
    input  logic                        i_store,
    input  logic [2:0]                  i_res_src,
    output logic                        o_stall,
    output logic                        o_valid,
    output logic [31:0]                 o_result,
    output logic [31:0]                 o_store_data,
    output logic [4:0]                  o_rd,
    output logic                        o_reg_write,
    output logic                        o_store,
    output logic [2:0]                  o_res_src,
    output logic [2:0]                  o_funct3,
    output logic                        o_redirect,
    output logic [IADDR_SPACE_BITS-1:0] o_redirect_pc
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [3:0]  shift_op;
    logic        pend_redirect;

    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        cond;
    logic        taken;
    logic        redirect;
    logic [IADDR_SPACE_BITS-1:0] redirect_pc;
    logic        is_shift;
    logic        start_serial;
    logic [31:0] acc_next;

    assign shamt   = i_op2[4:0];
    assign o_stall = (state == SHIFT);

    always_comb begin
        alu_res = i_op1 + i_op2;
        case (i_alu_op)
            OP_ADD:  alu_res = i_op1 + i_op2;
            OP_SUB:  alu_res = i_op1 - i_op2;
            OP_SLL:  alu_res = i_op1 << shamt;
            OP_SLT:  alu_res = {31'd0, $signed(i_op1) < $signed(i_op2)};
            OP_SLTU: alu_res = {31'd0, i_op1 < i_op2};
            OP_XOR:  alu_res = i_op1 ^ i_op2;
            OP_SRL:  alu_res = i_op1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(i_op1) >>> shamt);
            OP_OR:   alu_res = i_op1 | i_op2;
            OP_AND:  alu_res = i_op1 & i_op2;
            default: alu_res = i_op1 + i_op2;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (i_funct3)
            3'b000:  cond = (i_reg_data1 == i_reg_data2);
            3'b001:  cond = (i_reg_data1 != i_reg_data2);
            3'b100:  cond = ($signed(i_reg_data1) <  $signed(i_reg_data2));
            3'b101:  cond = ($signed(i_reg_data1) >= $signed(i_reg_data2));
            3'b110:  cond = (i_reg_data1 <  i_reg_data2);
            3'b111:  cond = (i_reg_data1 >= i_reg_data2);
            default: cond = 1'b0;
        endcase
    end

    assign taken       = i_inst_jal_jalr | (i_inst_branch & cond);
    assign redirect    = (i_inst_branch | i_inst_jal_jalr) & (taken != i_branch_pred);
    assign redirect_pc = taken ? i_pc_target : i_pc_next;

    assign is_shift     = (i_alu_op == OP_SLL) || (i_alu_op == OP_SRL) || (i_alu_op == OP_SRA);
    assign start_serial = (SERIAL_SHIFT != 0) && is_shift && (shamt != 5'd0);

    always_comb begin
        acc_next = acc;
        case (shift_op)
            OP_SLL:  acc_next = {acc[30:0], 1'b0};
            OP_SRL:  acc_next = {1'b0, acc[31:1]};
            OP_SRA:  acc_next = {acc[31], acc[31:1]};
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            shift_op      <= '0;
            pend_redirect <= 1'b0;
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_store_data  <= '0;
            o_rd          <= '0;
            o_reg_write   <= 1'b0;
            o_store       <= 1'b0;
            o_res_src     <= '0;
            o_funct3      <= '0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
        end else if (i_flush) begin
            state      <= IDLE;
            o_valid    <= 1'b0;
            o_redirect <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid    <= 1'b0;
                    o_redirect <= 1'b0;
                    if (i_valid) begin
                        // Pass-through fields and the redirect address are
                        // captured at accept for both paths; a serial shift
                        // only defers o_valid, o_result and o_redirect.
                        o_store_data  <= i_reg_data2;
                        o_rd          <= i_rd;
                        o_reg_write   <= i_reg_write;
                        o_store       <= i_store;
                        o_res_src     <= i_res_src;
                        o_funct3      <= i_funct3;
                        o_redirect_pc <= redirect_pc;
                        if (start_serial) begin
                            state         <= SHIFT;
                            acc           <= i_op1;
                            cnt           <= shamt;
                            shift_op      <= i_alu_op;
                            pend_redirect <= redirect;
                        end else begin
                            o_valid    <= 1'b1;
                            o_result   <= alu_res;
                            o_redirect <= redirect;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state      <= IDLE;
                        o_valid    <= 1'b1;
                        o_result   <= acc_next;
                        o_redirect <= pend_redirect;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv_alu2.md
Name: rv_alu2

Overview:
- Execute stage directly downstream of the operand-select stage. It computes the integer ALU result from the selected operands and resolves branches and jumps against the front-end prediction.
- It registers everything the memory/writeback stage needs and issues a registered redirect to the front end on a misprediction.
- Shifts run either single-cycle or on an iterative 1-bit/cycle shifter. The iterative shifter stalls the upstream stage while it runs.

Parameters:
- IADDR_SPACE_BITS, 32, width of PC/target/redirect addresses.
- SERIAL_SHIFT, 1, 1 = iterative shifter (stalls), 0 = single-cycle barrel shifter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_flush  in  1  kill in-flight and incoming instruction (trap/later-stage redirect)
- i_valid  in  1  instruction present at stage input
- i_op1, i_op2  in  32  selected ALU operands
- i_reg_data1, i_reg_data2  in  32  raw rs1/rs2 data (branch compare, store data)
- i_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 treated as ADD
- i_funct3  in  3  branch condition / memory size, passed through
- i_inst_branch, i_inst_jal_jalr, i_branch_pred  in  1 each  instruction class and front-end "taken" prediction
- i_pc_next, i_pc_target  in  IADDR_SPACE_BITS  fall-through address and computed target
- i_rd  in  5; i_reg_write, i_store  in  1; i_res_src  in  3  passed through
- o_stall  out  1  upstream must hold its registers
- o_valid  out  1  registered result valid
- o_result  out  32; o_store_data  out  32; o_rd  out  5; o_reg_write, o_store  out  1; o_res_src  out  3; o_funct3  out  3
- o_redirect  out  1  one-cycle front-end redirect
- o_redirect_pc  out  IADDR_SPACE_BITS  redirect address

Behaviour:
- Reset (async):
  - all outputs 0, including o_stall.
  - state IDLE; shift accumulator and counter 0.
- Accept: on a rising edge with i_valid=1, o_stall=0 and i_flush=0.
- Result arithmetic: 32-bit, wrap-around; shamt = i_op2[4:0]; SLT signed, SLTU unsigned, result 0/1.
- Branch condition (i_reg_data1 vs i_reg_data2, by funct3):
  - 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - 010 and 011 are never taken.
- taken = i_inst_jal_jalr | (i_inst_branch & cond).
- On accept, single-cycle path (non-shift op, shamt=0, or SERIAL_SHIFT=0):
  - next edge registers o_valid=1, result, pass-through fields and o_store_data=i_reg_data2.
  - o_redirect = (i_inst_branch|i_inst_jal_jalr) & (taken != i_branch_pred).
  - o_redirect_pc = taken ? i_pc_target : i_pc_next.
- Cycle with no accept: o_valid=0 and o_redirect=0. The data fields hold their last value.
- FSM (SERIAL_SHIFT=1), states IDLE and SHIFT:
  - IDLE->SHIFT on accepting SLL/SRL/SRA with shamt!=0. Load acc=i_op1 and cnt=shamt, and capture all pass-through fields plus the redirect decision. o_valid=0 on that edge.
  - In SHIFT: o_stall=1 (combinational from state). Each edge shifts acc by 1 (SRA replicates bit 31) and decrements cnt.
  - The edge where cnt==1: o_result=final value, o_valid=1, state->IDLE, o_stall drops.
  - Total: o_stall high for shamt cycles; o_valid rises shamt edges after the accepting edge.
  - Shift instructions never redirect unless flagged jump/branch (not legal, no checking).
- i_flush:
  - Highest priority: next edge forces o_valid=0 and o_redirect=0, and state->IDLE (aborts a shift).
  - Nothing is accepted that edge.
- Upstream holds inputs while o_stall=1; inputs are ignored in SHIFT.
- Reset mid-shift: immediate IDLE, all outputs 0.

Test Plan:
- ADD with op1=0xFFFFFFFF, op2=2 -> o_result=0x00000001, o_valid=1 one edge after accept, o_stall=0.
- BLT with data1=0xFFFFFFFE, data2=1, pred=0, pc_target=0x100, pc_next=0x84 -> o_redirect=1, o_redirect_pc=0x100. Same case with BLTU -> not taken, no redirect.
- JAL with pred=1 -> o_redirect=0. BEQ with equal data and pred=1 -> o_redirect=0. BNE with equal data and pred=1 -> o_redirect=1, o_redirect_pc=pc_next.
- SERIAL_SHIFT=1, SRA op1=0x80000000, shamt=4:
  - o_stall high for exactly 4 cycles; o_valid on the 4th edge with o_result=0xF8000000.
  - A back-to-back ADD presented meanwhile is accepted only after o_stall falls.
- SLL shamt=0 -> single-cycle, o_result=op1, no stall. SERIAL_SHIFT=0, SRL 0x80000000>>31 -> 0x00000001 in one cycle.
- i_flush asserted in the 2nd SHIFT cycle of a shamt=10 shift:
  - o_valid stays 0, o_stall falls next cycle, state IDLE.
  - Asserting i_reset mid-shift zeroes all outputs immediately.
